// File: rtl/bus_arbiter88.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter88
// Brief    : Shared-memory arbiter between a CPU and a DMA/video requester,
//            with programmable wait states and a CPU-slot fairness counter.
// Revision : 1.0
// ============================================================================
module bus_arbiter88 #(
    parameter int MEM_WAIT  = 0,
    parameter int CPU_SLOTS = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wreq,
    output logic        cpu_locked,
    input  logic        dma_req,
    input  logic [19:0] dma_address,
    input  logic [7:0]  dma_data,
    input  logic        dma_wreq,
    output logic        dma_ack,
    output logic [7:0]  dma_q,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_wreq,
    input  logic [7:0]  mem_bus
);

    // DMA_DONE has no bus cycle of its own; it is carried by r_dma_ack during
    // the first cycle of the following CPU access.
    typedef enum logic [2:0] {
        CPU_WAIT = 3'd0,
        CPU_STB  = 3'd1,
        DMA_WAIT = 3'd2,
        DMA_STB  = 3'd3
    } state_t;

    localparam logic [3:0] c_wait      = 4'(MEM_WAIT);
    localparam logic [4:0] c_slots     = 5'(CPU_SLOTS);
    localparam state_t     c_cpu_start = (MEM_WAIT == 0) ? CPU_STB : CPU_WAIT;
    localparam state_t     c_dma_start = (MEM_WAIT == 0) ? DMA_STB : DMA_WAIT;

    state_t      r_state;
    logic [3:0]  r_w;
    logic [3:0]  r_s;
    logic [7:0]  r_dma_q;
    logic        r_dma_ack;

    state_t      w_state_nxt;
    logic [3:0]  w_w_nxt;
    logic [3:0]  w_s_nxt;
    logic [7:0]  w_dma_q_nxt;
    logic        w_ack_nxt;
    logic        w_locked;
    logic        w_wreq;
    logic        w_dma_phase;
    logic [4:0]  w_s_inc;

    assign w_s_inc = {1'b0, r_s} + 5'd1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= c_cpu_start;
            r_w       <= 4'd0;
            r_s       <= 4'd0;
            r_dma_q   <= 8'd0;
            r_dma_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_w       <= w_w_nxt;
            r_s       <= w_s_nxt;
            r_dma_q   <= w_dma_q_nxt;
            r_dma_ack <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_s_nxt     = r_s;
        w_dma_q_nxt = r_dma_q;
        w_ack_nxt   = 1'b0;
        w_locked    = 1'b0;
        w_wreq      = 1'b0;
        case (r_state)
            CPU_WAIT: begin
                w_w_nxt = r_w + 4'd1;
                if (r_w + 4'd1 == c_wait) w_state_nxt = CPU_STB;
            end
            CPU_STB: begin
                w_locked = 1'b1;
                w_wreq   = cpu_wreq;
                w_w_nxt  = 4'd0;
                w_s_nxt  = (r_s == 4'hF) ? r_s : r_s + 4'd1;
                // dma_req is only ever sampled here, at the end of a CPU strobe
                if (dma_req && (w_s_inc >= c_slots)) w_state_nxt = c_dma_start;
                else                                 w_state_nxt = c_cpu_start;
            end
            DMA_WAIT: begin
                w_w_nxt = r_w + 4'd1;
                if (r_w + 4'd1 == c_wait) w_state_nxt = DMA_STB;
            end
            DMA_STB: begin
                w_wreq      = dma_wreq;
                w_w_nxt     = 4'd0;
                w_s_nxt     = 4'd0;
                w_ack_nxt   = 1'b1;
                w_state_nxt = c_cpu_start;
                if (!dma_wreq) w_dma_q_nxt = mem_bus;
            end
            default: begin
                w_w_nxt     = 4'd0;
                w_state_nxt = c_cpu_start;
            end
        endcase
    end

    assign w_dma_phase = (r_state == DMA_WAIT) || (r_state == DMA_STB);

    assign mem_address = w_dma_phase ? dma_address : cpu_address;
    assign mem_data    = w_dma_phase ? dma_data    : cpu_data;
    // Gated by resetn directly so nothing can be written while reset is held.
    assign cpu_locked  = resetn & w_locked;
    assign mem_wreq    = resetn & w_wreq;
    assign dma_ack     = r_dma_ack;
    assign dma_q       = r_dma_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter88.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter88
// Brief    : Directed self-checking bench; four parameterisations share inputs.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter88;

    logic        clock;
    logic        resetn;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_wreq;
    logic        dma_req;
    logic [19:0] dma_address;
    logic [7:0]  dma_data;
    logic        dma_wreq;

    int checks   = 0;
    int failures = 0;

    // A: MEM_WAIT=0 CPU_SLOTS=0, B: MEM_WAIT=2, C: CPU_SLOTS=3, D: MEM_WAIT=3
    logic        a_lock, a_ack, a_wreq, b_lock, b_ack, b_wreq;
    logic        c_lock, c_ack, c_wreq, d_lock, d_ack, d_wreq;
    logic [7:0]  a_q, b_q, c_q, d_q, a_md, b_md, c_md, d_md;
    logic [19:0] a_ma, b_ma, c_ma, d_ma;

    function automatic logic [7:0] mem_rd(input logic [19:0] a);
        return (a == 20'hB8000) ? 8'h41 : (a[7:0] ^ 8'h96);
    endfunction

    bus_arbiter88 #(.MEM_WAIT(0), .CPU_SLOTS(0)) u_a (
        .clock(clock), .resetn(resetn), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_wreq(cpu_wreq), .cpu_locked(a_lock), .dma_req(dma_req), .dma_address(dma_address),
        .dma_data(dma_data), .dma_wreq(dma_wreq), .dma_ack(a_ack), .dma_q(a_q),
        .mem_address(a_ma), .mem_data(a_md), .mem_wreq(a_wreq), .mem_bus(mem_rd(a_ma)));
    bus_arbiter88 #(.MEM_WAIT(2), .CPU_SLOTS(1)) u_b (
        .clock(clock), .resetn(resetn), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_wreq(cpu_wreq), .cpu_locked(b_lock), .dma_req(dma_req), .dma_address(dma_address),
        .dma_data(dma_data), .dma_wreq(dma_wreq), .dma_ack(b_ack), .dma_q(b_q),
        .mem_address(b_ma), .mem_data(b_md), .mem_wreq(b_wreq), .mem_bus(mem_rd(b_ma)));
    bus_arbiter88 #(.MEM_WAIT(0), .CPU_SLOTS(3)) u_c (
        .clock(clock), .resetn(resetn), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_wreq(cpu_wreq), .cpu_locked(c_lock), .dma_req(dma_req), .dma_address(dma_address),
        .dma_data(dma_data), .dma_wreq(dma_wreq), .dma_ack(c_ack), .dma_q(c_q),
        .mem_address(c_ma), .mem_data(c_md), .mem_wreq(c_wreq), .mem_bus(mem_rd(c_ma)));
    bus_arbiter88 #(.MEM_WAIT(3), .CPU_SLOTS(1)) u_d (
        .clock(clock), .resetn(resetn), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_wreq(cpu_wreq), .cpu_locked(d_lock), .dma_req(dma_req), .dma_address(dma_address),
        .dma_data(dma_data), .dma_wreq(dma_wreq), .dma_ack(d_ack), .dma_q(d_q),
        .mem_address(d_ma), .mem_data(d_md), .mem_wreq(d_wreq), .mem_bus(mem_rd(d_ma)));

    // Memory commit counters for the two write scenarios
    int b_commits = 0;
    int a_commits = 0;
    logic [7:0] b_last, a_last;
    always @(posedge clock) begin
        if (b_wreq && b_ma == 20'h12345) begin b_commits++; b_last = b_md; end
        if (a_wreq && a_ma == 20'h00400) begin a_commits++; a_last = a_md; end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    int acks;
    int base;

    initial begin
        resetn = 1'b0; cpu_address = '0; cpu_data = '0; cpu_wreq = 1'b1;
        dma_req = 1'b0; dma_address = '0; dma_data = '0; dma_wreq = 1'b0;

        // Reset state, outputs gated while resetn is low
        tick(); tick(); settle();
        check("rst_lock", a_lock, 0);
        check("rst_wreq", a_wreq, 0);
        check("rst_ack", a_ack, 0);
        check("rst_q", a_q, 0);
        cpu_wreq = 1'b0;

        // MEM_WAIT=0: CPU advances every cycle from the first cycle out of reset
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cpu_address = 20'h01111 * 20'(i + 1);
            settle();
            check("nowait_lock", a_lock, 1);
            check("nowait_addr", a_ma, cpu_address);
            tick();
        end

        // MEM_WAIT=2 CPU write: locked 0,0,1 and one strobe per access
        cpu_address = 20'h12345; cpu_data = 8'h5A; cpu_wreq = 1'b1;
        do_reset();
        base = b_commits;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("w2_lock", b_lock, (i == 2) ? 1 : 0);
            check("w2_wreq", b_wreq, (i == 2) ? 1 : 0);
            tick();
        end
        cpu_wreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("w2_lock2", b_lock, (i == 2) ? 1 : 0);
            tick();
        end
        check("w2_commits", b_commits - base, 1);
        check("w2_data", b_last, 8'h5A);

        // CPU_SLOTS=0 DMA read: grant right after the CPU strobe, ack next cycle
        cpu_address = 20'h00010; dma_address = 20'hB8000; dma_wreq = 1'b0;
        do_reset();
        dma_req = 1'b1;
        settle();
        check("rd_cpu0", a_lock, 1);
        tick();
        dma_req = 1'b0;
        settle();
        check("rd_stb_lock", a_lock, 0);
        check("rd_stb_addr", a_ma, 20'hB8000);
        check("rd_stb_wreq", a_wreq, 0);
        check("rd_stb_ack", a_ack, 0);
        tick(); settle();
        check("rd_ack", a_ack, 1);
        check("rd_q", a_q, 8'h41);
        check("rd_cpu1", a_lock, 1);
        tick(); settle();
        check("rd_ack_off", a_ack, 0);
        check("rd_q_hold", a_q, 8'h41);

        // CPU_SLOTS=3 with dma_req held: 3 CPU strobes then 1 DMA strobe
        dma_address = 20'h00777;
        do_reset();
        dma_req = 1'b1;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            check("slot3_lock", c_lock, (k % 4 != 3) ? 1 : 0);
            check("slot3_ack", c_ack, (k % 4 == 0 && k > 0) ? 1 : 0);
            if (c_ack) acks++;
            tick();
        end
        check("slot3_nacks", acks, 4);
        dma_req = 1'b0;

        // DMA write with dma_req dropped after grant: one commit, one ack
        dma_address = 20'h00400; dma_data = 8'hC3; dma_wreq = 1'b1;
        do_reset();
        base = a_commits;
        dma_req = 1'b1;
        tick();
        dma_req = 1'b0;
        settle();
        check("wr_stb_wreq", a_wreq, 1);
        check("wr_stb_data", a_md, 8'hC3);
        check("wr_stb_addr", a_ma, 20'h00400);
        tick(); settle();
        check("wr_ack", a_ack, 1);
        check("wr_q_untouched", a_q, 0);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            if (a_ack) acks++;
        end
        check("wr_no_more_acks", acks, 0);
        check("wr_commits", a_commits - base, 1);
        check("wr_commit_data", a_last, 8'hC3);

        // MEM_WAIT=3: reset during DMA_WAIT aborts the transfer
        dma_address = 20'h00999; dma_wreq = 1'b1; cpu_address = 20'h00ABC;
        do_reset();
        dma_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("w3_lock", d_lock, (k == 3) ? 1 : 0);
            check("w3_wreq", d_wreq, 0);
            tick();
        end
        resetn = 1'b0; dma_req = 1'b0;
        settle();
        check("w3_rst_lock", d_lock, 0);
        check("w3_rst_wreq", d_wreq, 0);
        tick(); settle();
        check("w3_rst_ack", d_ack, 0);
        check("w3_rst_q", d_q, 0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("w3_post_lock", d_lock, (k == 3) ? 1 : 0);
            check("w3_post_ack", d_ack, 0);
            check("w3_post_wreq", d_wreq, 0);
            check("w3_post_addr", d_ma, 20'h00ABC);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter88.md
BUS_ARBITER88 -- requirements
Module: bus_arbiter88

Interface
REQ-001 Parameter MEM_WAIT, default 0, sets wait cycles inserted before every memory strobe (legal 0..15).
REQ-002 Parameter CPU_SLOTS, default 1, sets the minimum completed CPU accesses between two DMA grants (legal 0..15).
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 cpu_address  input  20  CPU physical byte address.
REQ-006 cpu_data  input  8  CPU write byte.
REQ-007 cpu_wreq  input  1  CPU write request for the current address.
REQ-008 cpu_locked  output  1  CPU advance enable; the CPU executes one micro-step per cycle in which this is 1.
REQ-009 dma_req  input  1  secondary requester (DMA/video) transfer request, level.
REQ-010 dma_address  input  20  DMA byte address.
REQ-011 dma_data  input  8  DMA write byte.
REQ-012 dma_wreq  input  1  DMA transfer is a write (1) or read (0).
REQ-013 dma_ack  output  1  one-cycle pulse: DMA transfer complete, dma_q valid.
REQ-014 dma_q  output  8  DMA read byte, held until next DMA read completes.
REQ-015 mem_address  output  20  shared memory address.
REQ-016 mem_data  output  8  shared memory write byte.
REQ-017 mem_wreq  output  1  memory write strobe; memory commits mem_data on the rising edge where this is 1.
REQ-018 mem_bus  input  8  memory read byte, valid in the same cycle as mem_address (asynchronous read).

Function
REQ-019 States: CPU_WAIT, CPU_STB, DMA_WAIT, DMA_STB, DMA_DONE; 4-bit wait counter w; 4-bit saturating slot counter s.
REQ-020 CPU_WAIT/CPU_STB: mem_address=cpu_address, mem_data=cpu_data; DMA_WAIT/DMA_STB/DMA_DONE: mem_address=dma_address, mem_data=dma_data.
REQ-021 CPU_WAIT: cpu_locked=0, mem_wreq=0, w increments; move to CPU_STB when w==MEM_WAIT (immediately if MEM_WAIT=0, i.e. CPU_WAIT is skipped and CPU_STB entered directly).
REQ-022 CPU_STB: cpu_locked=1, mem_wreq=cpu_wreq, lasts exactly one cycle; s <= s+1 saturating at 15.
REQ-023 End of CPU_STB: if dma_req==1 and s+1 >= CPU_SLOTS, go to DMA phase (DMA_WAIT, or DMA_STB if MEM_WAIT=0); else start a new CPU access (w cleared).
REQ-024 DMA_WAIT: cpu_locked=0, mem_wreq=0, w increments; to DMA_STB when w==MEM_WAIT.
REQ-025 DMA_STB: cpu_locked=0, mem_wreq=dma_wreq, one cycle; if dma_wreq==0 dma_q <= mem_bus.
REQ-026 DMA_DONE is not a separate bus cycle: dma_ack=1 for exactly the first cycle after DMA_STB, coinciding with the first cycle of the next CPU access; s cleared to 0.
REQ-027 dma_req is sampled only at the end of CPU_STB; once granted the transfer completes even if dma_req drops.
REQ-028 Requester holds dma_address/dma_data/dma_wreq stable from dma_req rise until dma_ack; dma_req still 1 after ack is a new request.
REQ-029 CPU_SLOTS=0: DMA granted after every CPU access while dma_req=1; CPU never starved (>=1 CPU access between DMA transfers).
REQ-030 mem_wreq is 1 in at most one cycle per access, so each write commits exactly once regardless of MEM_WAIT.
REQ-031 MEM_WAIT=0, CPU_SLOTS=0, dma_req rising before edge ending CPU_STB at cycle t: DMA_STB at t+1, dma_ack at t+2.

Reset
REQ-032 resetn=0 at a rising edge: state CPU access start (w=0), s=0, dma_q=0, dma_ack=0.
REQ-033 While resetn=0: cpu_locked=0 and mem_wreq=0 combinationally, no memory write occurs.
REQ-034 Reset mid-DMA aborts the transfer with no ack; requester must re-request.
REQ-035 First cycle after reset release, MEM_WAIT=0: CPU_STB with cpu_locked=1.

Verification
REQ-036 MEM_WAIT=0, dma_req=0, 10 cycles -> cpu_locked=1 every cycle, mem_address tracks cpu_address.
REQ-037 MEM_WAIT=2, CPU write 0x5A @0x12345 -> cpu_locked pattern 0,0,1 repeating; mem_wreq=1 only in the third cycle; memory 0x12345=0x5A once.
REQ-038 CPU_SLOTS=0, DMA read @0xB8000 holding 0x41 -> one cycle cpu_locked=0, mem_address=0xB8000; next cycle dma_ack=1, dma_q=0x41.
REQ-039 CPU_SLOTS=3, dma_req held high 20 cycles, MEM_WAIT=0 -> repeating pattern 3 CPU strobes, 1 DMA strobe; dma_ack every 4th cycle.
REQ-040 DMA write 0xC3 @0x00400, dma_req dropped after grant -> write commits once, dma_ack pulses, no second transfer.
REQ-041 resetn=0 during DMA_WAIT (MEM_WAIT=3) -> no mem_wreq, no dma_ack, dma_q=0, CPU_STB first after release.
